// File: rtl/pipelined_adder.sv
// Ready/valid pipelined ripple adder/subtractor: each stage adds CHUNK bits
// and registers its carry for the next stage. WIDTH must be a multiple of CHUNK.
module pipelined_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int STAGES = WIDTH / CHUNK;

    logic              adv;
    logic [STAGES-1:0] vld_q, cy_q;
    logic [STAGES-1:0] vld_in, cy_in, cy_d;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  s_in [STAGES];
    logic [WIDTH-1:0]  s_d  [STAGES];
    logic [CHUNK:0]    part [STAGES];

    // The whole pipe moves as one; a full output stage that is not being
    // taken freezes every stage, including bubbles.
    assign adv       = !vld_q[STAGES-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = cy_q[STAGES-1];
    assign ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                       (s_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

    always_comb begin
        // Stage 0 takes the raw operands; subtraction becomes a + ~b + 1.
        vld_in[0] = in_valid;
        cy_in[0]  = sub | cin;
        a_in[0]   = a;
        b_in[0]   = sub ? ~b : b;
        s_in[0]   = '0;
        for (int k = 1; k < STAGES; k++) begin
            vld_in[k] = vld_q[k-1];
            cy_in[k]  = cy_q[k-1];
            a_in[k]   = a_q[k-1];
            b_in[k]   = b_q[k-1];
            s_in[k]   = s_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            part[k] = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
                    + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
                    + {{CHUNK{1'b0}}, cy_in[k]};
            s_d[k]                   = s_in[k];
            s_d[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
            cy_d[k]                  = part[k][CHUNK];
        end
    end

    // NOTE: data registers are reset too, so sum/cout/ovf read 0 in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            cy_q  <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (adv) begin
            vld_q <= vld_in;
            cy_q  <= cy_d;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_d[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=16, CHUNK=4, latency 4):
// the driver queues hand-computed results, a monitor checks each output.
module tb_pipelined_adder;
    localparam int WIDTH = 16;
    localparam int LAT   = 4;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          idx;
        bit          lat_chk;
        int          due;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             sub = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    vec_t vecs [12];
    exp_t exp_q [$];

    pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                                input logic vs, input logic [15:0] vsum, input logic vco,
                                input logic vov);
        vec_t v;
        v.a = va; v.b = vb; v.cin = vc; v.sub = vs;
        v.sum = vsum; v.cout = vco; v.ovf = vov;
        return v;
    endfunction

    task automatic push(input int idx, input bit lat_chk);
        exp_t e;
        e.sum = vecs[idx].sum; e.cout = vecs[idx].cout; e.ovf = vecs[idx].ovf;
        e.idx = idx; e.lat_chk = lat_chk; e.due = cyc + LAT;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int idx);
        a = vecs[idx].a; b = vecs[idx].b; cin = vecs[idx].cin; sub = vecs[idx].sub;
    endtask

    // Entered and left at posedge+1; waits a bounded time for in_ready.
    task automatic issue(input int idx, input bit lat_chk);
        bit done = 1'b0;
        drive(idx);
        in_valid = 1'b1;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                push(idx, lat_chk);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) check("issue_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain_empty", exp_q.size(), 32'd0);
    endtask

    // Monitor: compares each accepted result and checks held outputs stay put.
    logic [17:0] held;
    bit          held_v = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold_valid", {31'd0, out_valid}, 32'd1);
                check("hold_stable", {14'd0, sum, cout, ovf}, {14'd0, held});
            end
            held_v = out_valid && !out_ready;
            held   = {sum, cout, ovf};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {31'd0, out_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check($sformatf("sum[%0d]", e.idx), {16'd0, sum}, {16'd0, e.sum});
                    check($sformatf("cout[%0d]", e.idx), {31'd0, cout}, {31'd0, e.cout});
                    check($sformatf("ovf[%0d]", e.idx), {31'd0, ovf}, {31'd0, e.ovf});
                    if (e.lat_chk) check($sformatf("latency[%0d]", e.idx), cyc, e.due);
                end
            end
        end
    end

    initial begin
        vecs[0]  = mk(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0);
        vecs[1]  = mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        vecs[2]  = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        vecs[3]  = mk(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        vecs[4]  = mk(16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0);
        vecs[5]  = mk(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        vecs[6]  = mk(16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h00FE, 1'b1, 1'b0);
        vecs[7]  = mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        vecs[8]  = mk(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        vecs[9]  = mk(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0);
        vecs[10] = mk(16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        vecs[11] = mk(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Reset asserted before any clock edge: outputs must clear asynchronously.
        #1 rst = 1'b1;
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_cout_ovf", {30'd0, cout, ovf}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        // Directed single transactions with latency check.
        for (int i = 0; i < 4; i++) issue(i, 1'b1);
        drain();

        // Eight back-to-back with out_ready low on burst cycles 5-7.
        begin
            int idx = 0;
            for (int c = 1; c <= 40 && idx < 8; c++) begin
                out_ready = !(c >= 5 && c <= 7);
                in_valid  = 1'b1;
                drive(4 + idx);
                @(negedge clk);
                if (c >= 5 && c <= 7) check($sformatf("stall_in_ready_c%0d", c), {31'd0, in_ready}, 32'd0);
                if (in_ready) begin
                    push(4 + idx, 1'b0);
                    idx++;
                end
                @(posedge clk); #1;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            check("burst_all_issued", idx, 32'd8);
        end
        drain();

        // Reset with three transactions in flight.
        for (int i = 0; i < 3; i++) issue(4 + i, 1'b0);
        #1 rst = 1'b1;
        exp_q.delete();
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_sum", {16'd0, sum}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_idle_%0d", i), {31'd0, out_valid}, 32'd0);
        end
        @(posedge clk); #1;
        issue(0, 1'b1);
        drain();

        // Alternating in_valid: out_valid must follow with a 4-cycle offset.
        begin
            bit hist [12];
            for (int i = 0; i < 12; i++) begin
                in_valid = (i % 2 == 0);
                drive(4 + (i / 2));
                @(negedge clk);
                hist[i] = in_valid && in_ready;
                if (hist[i]) push(4 + (i / 2), 1'b1);
                if (i >= LAT) check($sformatf("alt_out_valid_%0d", i), {31'd0, out_valid}, {31'd0, hist[i-LAT]});
                @(posedge clk); #1;
            end
            in_valid = 1'b0;
        end
        drain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per pipeline stage; WIDTH SHALL be a multiple of CHUNK; STAGES = WIDTH/CHUNK.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: operands present this cycle.
REQ-006 SHALL have port in_ready, output, 1: adder accepts operands this cycle.
REQ-007 SHALL have port a, input, WIDTH: operand A, unsigned or two's complement.
REQ-008 SHALL have port b, input, WIDTH: operand B.
REQ-009 SHALL have port cin, input, 1: carry in, used only when sub=0.
REQ-010 SHALL have port sub, input, 1: 0 = add, 1 = subtract.
REQ-011 SHALL have port out_valid, output, 1: result present.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts result.
REQ-013 SHALL have port sum, output, WIDTH: result.
REQ-014 SHALL have port cout, output, 1: carry out of the MSB.
REQ-015 SHALL have port ovf, output, 1: signed overflow.

Function
REQ-016 SHALL compute a + b + cin when sub=0, and a + ~b + 1 when sub=1 (cin ignored); result truncated to WIDTH, with the carry out of bit WIDTH-1 on cout.
REQ-017 SHALL set ovf = 1 iff a and the effective B operand (b when sub=0, ~b when sub=1) have equal MSBs and sum MSB differs from them.
REQ-018 SHALL split the add into STAGES chunks, LSB chunk first: stage k adds bits [k*CHUNK +: CHUNK] plus the carry registered by stage k-1.
REQ-019 SHALL delay the not-yet-added operand chunks, and the completed sum chunks, in registers so that each transaction's bits stay aligned through the pipeline.
REQ-020 SHALL accept a transaction on a cycle where in_valid=1 and in_ready=1.
REQ-021 SHALL assert out_valid exactly STAGES cycles after acceptance when out_ready is held 1 (latency STAGES, throughput 1 per cycle).
REQ-022 SHALL advance all stages together only when adv = (!out_valid || out_ready); when adv=0 all stage registers, including valid bits, SHALL hold.
REQ-023 SHALL drive in_ready = adv, combinationally.
REQ-024 SHALL keep sum, cout and ovf stable while out_valid=1 and out_ready=0.
REQ-025 SHALL carry a per-stage valid bit; a bubble (in_valid=0 while adv=1) SHALL propagate as an invalid stage, and SHALL NOT be squeezed out.
REQ-026 SHALL, with STAGES=1, behave as a single registered adder with latency 1.
REQ-027 SHALL keep in-flight transactions independent: a sub or cin change between back-to-back transactions SHALL NOT affect earlier ones.
REQ-028 SHALL drop no transaction and duplicate none under any in_valid/out_ready pattern.

Reset
REQ-029 SHALL, while rst=1, force every stage valid bit to 0 and out_valid=0, sum=0, cout=0, ovf=0, independent of clk.
REQ-030 SHALL discard all in-flight transactions when rst is asserted mid-operation; no result from them SHALL appear after release.
REQ-031 SHALL drive in_ready=1 during reset and on the first cycle after release, since out_valid=0.

Verification (WIDTH=16, CHUNK=4, latency 4)
REQ-032 Bench SHALL cover: a=0x0001, b=0x0002, cin=0, sub=0 -> 4 cycles later sum=0x0003, cout=0, ovf=0.
REQ-033 Bench SHALL cover: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples across all four stages).
REQ-034 Bench SHALL cover: a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, ovf=1; then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
REQ-035 Bench SHALL cover: 8 back-to-back transactions with out_ready=0 on cycles 5-7 -> in_ready=0 on those cycles, all 8 results in order, held values stable, none lost.
REQ-036 Bench SHALL cover: rst pulsed with 3 transactions in flight -> out_valid stays 0 until a new transaction completes 4 cycles after acceptance.
REQ-037 Bench SHALL cover: alternating in_valid 1/0 -> out_valid alternates 1/0 with 4-cycle offset, results correct.
